// File: rtl/spi_reg_bank.sv
// spi_reg_bank: write-only SPI (mode 0) slave that updates a five-entry 8-bit
// control register bank from 16-bit frames {rw, addr[6:0], data[7:0]}.
// The SPI pins are asynchronous to clk and are synchronized internally.
// Handshake: there is no valid/ready pair. A committed frame produces exactly
// one single-cycle pulse: wr_strobe for an accepted write, or frame_err for a
// frame whose bit count is not 16. The register update lands on the same edge
// as wr_strobe, and the two pulses are never high together.
module spi_reg_bank #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] MAX_A   = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_OVF  = 5'd17;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_d;
  logic                   ncs_d;
  logic                   sclk_s;
  logic                   copi_s;
  logic                   ncs_s;
  logic                   sclk_rise;
  logic                   ncs_rise;
  logic                   ncs_fall;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] shreg;
  logic [4:0]  cnt;

  logic [7:0]  reg0, reg1, reg2, reg3, reg4;
  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;

  // Synchronizer chains plus one extra flop on sclk/ncs for edge detection.
  // Everything clears to 0, so a reset released mid-frame (ncs still low)
  // sees no falling edge and stays in IDLE until a fresh frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A falling ncs seen during COMMIT starts the next frame
  // directly, so it is not lost when the edge detector moves on.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ncs_fall) state_d = SHIFT;
      SHIFT:   if (ncs_rise) state_d = COMMIT;
      COMMIT:  state_d = ncs_fall ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register and saturating bit counter. An sclk edge coinciding with
  // the ncs rise is dropped so the frame is judged on the earlier count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt <= '0;
          if (ncs_fall) shreg <= '0;
        end
        SHIFT: begin
          if (sclk_rise && !ncs_rise) begin
            shreg <= {shreg[14:0], copi_s};
            if (cnt != CNT_OVF) cnt <= cnt + 5'd1;
          end
        end
        COMMIT: begin
          if (ncs_fall) begin
            shreg <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          shreg <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign frame_addr = shreg[14:8];
  assign frame_data = shreg[7:0];

  // Frame evaluation in COMMIT: register write with wr_strobe, or frame_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg0      <= 8'h00;
      reg1      <= 8'h00;
      reg2      <= 8'h00;
      reg3      <= 8'h00;
      reg4      <= 8'h00;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (state_q == COMMIT) begin
        if (cnt != CNT_FULL) begin
          frame_err <= 1'b1;
        end else if (shreg[15] && (frame_addr <= MAX_A) && (frame_addr < 7'd5)) begin
          wr_strobe <= 1'b1;
          case (frame_addr[2:0])
            3'd0:    reg0 <= frame_data;
            3'd1:    reg1 <= frame_data;
            3'd2:    reg2 <= frame_data;
            3'd3:    reg3 <= frame_data;
            3'd4:    reg4 <= frame_data;
            default: ;
          endcase
        end
      end
    end
  end

  assign en_reg_out_7_0  = reg0;
  assign en_reg_out_15_8 = reg1;
  assign en_reg_pwm_7_0  = reg2;
  assign en_reg_pwm_15_8 = reg3;
  assign pwm_duty_cycle  = reg4;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: drives SPI frames into spi_reg_bank and scores each
// wr_strobe/frame_err pulse against a queue of expected events.
module tb_spi_reg_bank;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic       frame_err;

  // Expected event: {kind[1:0] = {wr,err}, addr[2:0], data[7:0]}
  localparam int W = 13;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [7:0]   model [5];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_cyc = 0;

  spi_reg_bank #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_reg(input int i);
    case (i)
      0:       return en_reg_out_7_0;
      1:       return en_reg_out_15_8;
      2:       return en_reg_pwm_7_0;
      3:       return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    ncs = 1'b0;
    tick(4);
  endtask

  task automatic shift_bits(input logic [16:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = d[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    tick(3);
    ncs = 1'b1;
    rise_cyc = cyc;
    tick(10);
  endtask

  task automatic check_bank();
    for (int i = 0; i < 5; i++) check($sformatf("reg%0d", i), get_reg(i), model[i]);
  endtask

  // A well-formed 16-bit frame; only in-range writes produce an event.
  task automatic send16(input logic [15:0] w);
    if (w[15] && (w[14:8] <= 7'd4)) begin
      exp_q.push_back({2'b10, w[10:8], w[7:0]});
      model[w[10:8]] = w[7:0];
    end
    start_frame();
    shift_bits({1'b0, w}, 16);
    end_frame();
    check_bank();
  endtask

  // A frame with the wrong bit count.
  task automatic send_bad(input logic [16:0] d, input int n);
    exp_q.push_back({2'b01, 3'd0, 8'h00});
    start_frame();
    shift_bits(d, n);
    end_frame();
    check_bank();
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && (wr_strobe || frame_err)) begin
      check("both_pulses", {31'd0, wr_strobe & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, wr_strobe, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, wr_strobe, frame_err}, {30'd0, e[12:11]});
        check("latency", cyc - rise_cyc, 4);
        if (e[12]) check("written_value", get_reg(int'(e[10:8])), e[7:0]);
      end
    end
  end

  initial begin
    logic [15:0] w;
    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    tick(3);
    check_bank();
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Basic writes to each register
    send16(16'h80F0);
    send16(16'h81CC);
    send16(16'h8255);
    send16(16'h83AA);
    send16(16'h8480);

    // Read and out-of-range frames are ignored
    send16(16'h0012);
    send16(16'h8577);

    // 15-bit and 17-bit frames starting with 0x80
    send_bad(17'h04078, 15);
    send_bad(17'h101E1, 17);

    // Reset in the middle of a frame
    start_frame();
    shift_bits(17'h00084, 8);
    rst  = 1'b1;
    ncs  = 1'b1;
    sclk = 1'b0;
    tick(2);
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    check("mid_rst_duty", {24'd0, pwm_duty_cycle}, 32'd0);
    rst = 1'b0;
    tick(6);
    check_bank();
    send16(16'h8433);

    // sclk toggles while deselected have no effect
    for (int i = 0; i < 16; i++) begin
      copi = 1'($urandom_range(0, 1));
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(6);
    check_bank();
    send16(16'h83A5);

    // Same value rewritten, then random in-range writes
    send16(16'h83A5);
    for (int i = 0; i < 4; i++) begin
      w = {1'b1, 7'($urandom_range(0, 4)), 8'($urandom_range(0, 255))};
      send16(w);
    end

    tick(10);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

SPI write-only peripheral that receives 16-bit frames from an external SPI controller and updates a five-entry 8-bit control register bank. It sits directly upstream of the PWM/output stage inside the top-level user project. It drives that stage's output-enable, PWM-enable and duty-cycle registers from the SPI pins on `ui_in`. All SPI pins are asynchronous to `clk` and are synchronized internally.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per SPI input (legal ≥ 2).
- `MAX_ADDR`, 4: highest valid register address; addresses above it are ignored.

- `clk`  in  1  system clock (10 MHz nominal).
- `rst`  in  1  reset. Active-high and asynchronous: asserting it immediately clears all state.
- `sclk`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); data sampled on rising edge.
- `copi`  in  1  SPI data in, MSB first.
- `ncs`  in  1  SPI chip select, active-low.
- `en_reg_out_7_0`  out  8  register 0x00.
- `en_reg_out_15_8`  out  8  register 0x01.
- `en_reg_pwm_7_0`  out  8  register 0x02.
- `en_reg_pwm_15_8`  out  8  register 0x03.
- `pwm_duty_cycle`  out  8  register 0x04.
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded because its bit count ≠ 16.

## Operation
- Frame format, 16 bits, MSB first:
  - bit 15: R/W (1 = write, 0 = read).
  - bits 14:8: 7-bit address.
  - bits 7:0: data.
- Reads are unsupported. A frame with bit 15 = 0 is silently ignored: no `wr_strobe`, no `frame_err`.
- Synchronization: `sclk`, `copi` and `ncs` each pass through `SYNC_STAGES` flops. A further flop on `sclk_s` and on `ncs_s` provides edge detection.
- State machine:
  - IDLE: `ncs_s` high. Bit counter held at 0.
  - On `ncs_s` falling edge: go to SHIFT and clear the shift register and counter.
  - SHIFT: each `sclk_s` rising edge shifts `copi_s` into the LSB of the 16-bit shift register and increments the 5-bit counter. The counter saturates at 17, meaning overflow.
  - On `ncs_s` rising edge: go to COMMIT.
  - COMMIT (one cycle), then return to IDLE:
    - If count = 16, bit 15 = 1 and address ≤ `MAX_ADDR`: write the data byte to that register and pulse `wr_strobe`.
    - If count ≠ 16: pulse `frame_err`. No register changes.
    - If count = 16, bit 15 = 1 and address > `MAX_ADDR`: no register changes and no pulse.
- An `sclk_s` rising edge while `ncs_s` is high is ignored.
- A simultaneous `sclk_s` rise and `ncs_s` rise in the same cycle: the `sclk` edge is ignored, and the frame is evaluated with the count before that edge.
- An `ncs_s` falling edge that arrives while in COMMIT is honoured on the next cycle. Controllers are required to keep `ncs` high for ≥ 4 `clk` periods between frames.
- Registers hold their value until rewritten or reset. Writing the same value again still pulses `wr_strobe`.

## Timing
- Reset values:
  - All five registers: 0x00.
  - `wr_strobe` = 0, `frame_err` = 0.
  - State = IDLE; shift register and counter = 0.
- Reset mid-frame: the frame is abandoned. After `rst` deasserts, the block waits in IDLE. No COMMIT occurs until a fresh `ncs_s` falling edge.
- Input constraint: `sclk` high and low phases each ≥ 3 `clk` periods. `copi` is stable for ≥ 3 `clk` periods around each `sclk` rising edge.
- Latency from the external `ncs` rising edge to the register update and `wr_strobe` is `SYNC_STAGES` + 2 `clk` edges, i.e. 4 at default:
  - The register value and `wr_strobe` change on the same edge.
  - `wr_strobe` is high for exactly one cycle.
- `frame_err` has the same latency as `wr_strobe` and is never high in the same cycle.

## Test plan
- Reset with `rst` = 1 → all registers 0x00 and both pulses 0. Then send frame 0x80F0 → `en_reg_out_7_0` = 0xF0 exactly 4 cycles after `ncs` rises, with one `wr_strobe` pulse.
- Send frames 0x81CC, 0x8255, 0x83AA and 0x8480 → registers 0x01 through 0x04 read 0xCC, 0x55, 0xAA and 0x80; other registers unchanged; four `wr_strobe` pulses.
- Send read frame 0x0012 and out-of-range frame 0x8577 → no register change, no `wr_strobe`, no `frame_err`.
- Send a 15-bit frame and then a 17-bit frame, both starting with 0x80 → each produces one `frame_err` pulse; `en_reg_out_7_0` keeps its prior value.
- Assert `rst` after 8 bits of frame 0x84FF, release it, then send 0x8433 → `pwm_duty_cycle` = 0x00 after the reset, then 0x33 after the new frame.
- Toggle `sclk` 16 times with `ncs` high, then send 0x83A5 → only `en_reg_pwm_15_8` = 0xA5 is written; the idle toggles have no effect.
